// File: rtl/matrix_pkg.sv
// Shared LSTM-gate helpers: activation codes, accumulator sizing, saturate/clamp/reduce.
// MATRIX_GATE_SAT_EN selects saturating width reductions; otherwise they wrap.
package matrix_pkg;

   localparam int ACT_SIGMOID = 0;
   localparam int ACT_TANH    = 1;
   localparam int ACT_IDENT   = 2;

   function automatic int acc_width(input int dw, input int n, input int m);
      return 2 * dw + $clog2((n > m) ? n : m) + 1;
   endfunction

   function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                input logic signed [63:0] lo,
                                                input logic signed [63:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
      logic signed [63:0] maxv;
      logic signed [63:0] minv;
      maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
      minv = -(64'sd1 <<< (w - 1));
      return clamp(v, minv, maxv);
   endfunction

   // Result is the w-bit value sign-extended back to 64 bits.
   function automatic logic signed [63:0] reduce(input logic signed [63:0] v, input int w);
`ifdef MATRIX_GATE_SAT_EN
      return sat(v, w);
`else
      return (v <<< (64 - w)) >>> (64 - w);
`endif
   endfunction

endpackage

// File: rtl/mat_vec_mult.sv
// Combinational W*v per row, full-precision sum, one floor shift by FRACT_WIDTH, reduce to DATA_WIDTH.
// Zero latency, no flow control.
module mat_vec_mult
   import matrix_pkg::*;
#(
   parameter int ROWS        = 16,
   parameter int COLS        = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8
) (
   input  logic [ROWS*COLS*DATA_WIDTH-1:0] w,
   input  logic [COLS*DATA_WIDTH-1:0]      v,
   output logic [ROWS*DATA_WIDTH-1:0]      p
);

   localparam int ACC_W = acc_width(DATA_WIDTH, COLS, ROWS);
   localparam int PW    = 2 * DATA_WIDTH;

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] acc;

   always_comb begin
      p    = '0;
      prod = '0;
      acc  = '0;
      for (int r = 0; r < ROWS; r++) begin
         acc = '0;
         for (int c = 0; c < COLS; c++) begin
            prod = $signed(w[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH]) *
                   $signed(v[c*DATA_WIDTH +: DATA_WIDTH]);
            acc  = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
         end
         // Shift once after the sum so rounding is a single floor, not per product.
         p[r*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(reduce(64'(acc >>> FRACT_WIDTH), DATA_WIDTH));
      end
   end

endmodule

// File: rtl/matrix_gate_adder.sv
// LSTM gate pre-activation y = act(Wx*x + bx + Wh*h + bh); 1-cycle latency, 1 vector/cycle, no backpressure.
// MATRIX_GATE_SAT_EN (via matrix_pkg) makes px/ph/s reductions saturate instead of wrap.
module matrix_gate_adder
   import matrix_pkg::*;
#(
   parameter int M           = 16,
   parameter int N           = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8,
   parameter int LOGIC_TYPE  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [M*N*DATA_WIDTH-1:0] wx,
   input  logic [M*M*DATA_WIDTH-1:0] wh,
   input  logic [M*DATA_WIDTH-1:0]   bx,
   input  logic [M*DATA_WIDTH-1:0]   bh,
   input  logic [N*DATA_WIDTH-1:0]   x,
   input  logic [M*DATA_WIDTH-1:0]   h,
   output logic [M*DATA_WIDTH-1:0]   y,
   output logic                      out_valid
);

   if (LOGIC_TYPE != ACT_SIGMOID && LOGIC_TYPE != ACT_TANH && LOGIC_TYPE != ACT_IDENT) begin : g_bad_type
      $error("matrix_gate_adder: unsupported LOGIC_TYPE %0d", LOGIC_TYPE);
   end

   localparam logic signed [63:0] ONE  = 64'sd1 <<< FRACT_WIDTH;
   localparam logic signed [63:0] HALF = ONE >>> 1;

   logic [M*DATA_WIDTH-1:0]      px;
   logic [M*DATA_WIDTH-1:0]      ph;
   logic [M*DATA_WIDTH-1:0]      y_next;
   logic signed [DATA_WIDTH+1:0] sum;
   logic signed [63:0]           s;
   logic [DATA_WIDTH-1:0]        a;

   mat_vec_mult #(
      .ROWS(M), .COLS(N), .DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH)
   ) u_px (
      .w(wx), .v(x), .p(px)
   );

   mat_vec_mult #(
      .ROWS(M), .COLS(M), .DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH)
   ) u_ph (
      .w(wh), .v(h), .p(ph)
   );

   always_comb begin
      y_next = '0;
      sum    = '0;
      s      = '0;
      a      = '0;
      for (int r = 0; r < M; r++) begin
         sum = (DATA_WIDTH+2)'($signed(px[r*DATA_WIDTH +: DATA_WIDTH])) +
               (DATA_WIDTH+2)'($signed(bx[r*DATA_WIDTH +: DATA_WIDTH])) +
               (DATA_WIDTH+2)'($signed(ph[r*DATA_WIDTH +: DATA_WIDTH])) +
               (DATA_WIDTH+2)'($signed(bh[r*DATA_WIDTH +: DATA_WIDTH]));
         s = reduce(64'(sum), DATA_WIDTH);
         if (LOGIC_TYPE == ACT_SIGMOID)
            a = DATA_WIDTH'(clamp((s >>> 2) + HALF, 64'sd0, ONE));
         else if (LOGIC_TYPE == ACT_TANH)
            a = DATA_WIDTH'(clamp(s, -ONE, ONE));
         else
            a = DATA_WIDTH'(s);
         y_next[r*DATA_WIDTH +: DATA_WIDTH] = a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            y <= y_next;
      end
   end

endmodule

// File: tb/tb_matrix_gate_adder.sv
// Directed-vector bench: three M=N=2 Q8.8 instances (one per activation) sharing operands,
// plus an M=N=1 identity instance for the reduction-saturation case.
module tb_matrix_gate_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;

   logic [63:0] wx = '0;
   logic [63:0] wh = '0;
   logic [31:0] bx = '0;
   logic [31:0] bh = '0;
   logic [31:0] x  = '0;
   logic [31:0] h  = '0;

   logic [15:0] wx1 = '0;
   logic [15:0] wh1 = '0;
   logic [15:0] bx1 = '0;
   logic [15:0] bh1 = '0;
   logic [15:0] x1  = '0;
   logic [15:0] h1  = '0;

   logic [31:0] y_id, y_sig, y_tanh;
   logic [15:0] y_one;
   logic        ov_id, ov_sig, ov_tanh, ov_one;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   matrix_gate_adder #(.M(2), .N(2), .DATA_WIDTH(16), .FRACT_WIDTH(8), .LOGIC_TYPE(2)) u_id (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wx(wx), .wh(wh), .bx(bx), .bh(bh),
      .x(x), .h(h), .y(y_id), .out_valid(ov_id));

   matrix_gate_adder #(.M(2), .N(2), .DATA_WIDTH(16), .FRACT_WIDTH(8), .LOGIC_TYPE(0)) u_sig (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wx(wx), .wh(wh), .bx(bx), .bh(bh),
      .x(x), .h(h), .y(y_sig), .out_valid(ov_sig));

   matrix_gate_adder #(.M(2), .N(2), .DATA_WIDTH(16), .FRACT_WIDTH(8), .LOGIC_TYPE(1)) u_tanh (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wx(wx), .wh(wh), .bx(bx), .bh(bh),
      .x(x), .h(h), .y(y_tanh), .out_valid(ov_tanh));

   matrix_gate_adder #(.M(1), .N(1), .DATA_WIDTH(16), .FRACT_WIDTH(8), .LOGIC_TYPE(2)) u_one (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wx(wx1), .wh(wh1), .bx(bx1), .bh(bh1),
      .x(x1), .h(h1), .y(y_one), .out_valid(ov_one));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      check("rst_y_id",   64'(y_id),   64'h0);
      check("rst_ov_id",  64'(ov_id),  64'h0);
      check("rst_y_one",  64'(y_one),  64'h0);
      check("rst_ov_sig", 64'(ov_sig), 64'h0);

      // Identity Wx, x passes through one cycle later.
      rst      = 1'b0;
      in_valid = 1'b1;
      wx       = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
      x        = {16'h0200, 16'h0100};
      step();
      check("v1_y",  64'(y_id),  64'h0200_0100);
      check("v1_ov", 64'(ov_id), 64'h1);

      // Both products plus both biases, including a negative element.
      wh = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
      x  = {16'hFF80, 16'h0080};
      h  = {16'hFF80, 16'h0080};
      bx = {16'h0000, 16'h0100};
      bh = {16'h0040, 16'h0000};
      step();
      check("v2_y", 64'(y_id), 64'hFF40_0200);

      in_valid = 1'b0;
      bx       = {16'h1234, 16'h5678};
      step();
      check("idle_ov", 64'(ov_id), 64'h0);
      check("idle_y",  64'(y_id),  64'hFF40_0200);

      // Biases alone set s per row to exercise the activations.
      in_valid = 1'b1;
      wx = '0; wh = '0; x = '0; h = '0; bh = '0;
      bx = {16'h0400, 16'h0000};
      step();
      check("sig_a",  64'(y_sig),  64'h0100_0080);
      check("tanh_a", 64'(y_tanh), 64'h0100_0000);
      check("id_a",   64'(y_id),   64'h0400_0000);
      check("sig_ov", 64'(ov_sig), 64'h1);

      bx = {16'hFF00, 16'h0300};
      step();
      check("tanh_b", 64'(y_tanh), 64'hFF00_0100);
      check("sig_b",  64'(y_sig),  64'h0040_0100);

      bx = {16'hFE00, 16'hFC00};
      step();
      check("sig_c",  64'(y_sig),  64'h0000_0000);
      check("tanh_c", 64'(y_tanh), 64'hFF00_FF00);

      // Floor shift applied after the sum, not per product.
      bx  = '0;
      wx  = {16'h0080, 16'h0080, 16'h0000, 16'h0080};
      x   = {16'h0001, 16'hFFFF};
      wx1 = 16'h0100;
      x1  = 16'h7F00;
      bx1 = 16'h7F00;
      step();
      check("floor_y", 64'(y_id), 64'h0000_FFFF);
`ifdef MATRIX_GATE_SAT_EN
      check("sat_y", 64'(y_one), 64'h7FFF);
`else
      check("wrap_y", 64'(y_one), 64'hFE00);
`endif

      // Reset mid-stream drops the in-flight vector.
      wx = '0; x = '0;
      bx = {16'h0011, 16'h0010};
      step();
      check("s1_y", 64'(y_id), 64'h0011_0010);
      bx  = {16'h0021, 16'h0020};
      rst = 1'b1;
      step();
      check("s2_rst_y",  64'(y_id),  64'h0);
      check("s2_rst_ov", 64'(ov_id), 64'h0);
      rst      = 1'b0;
      in_valid = 1'b0;
      bx       = {16'h0031, 16'h0030};
      step();
      check("s3_nopres_ov", 64'(ov_id), 64'h0);
      check("s3_nopres_y",  64'(y_id),  64'h0);
      in_valid = 1'b1;
      step();
      check("s3_y",  64'(y_id),  64'h0031_0030);
      check("s3_ov", 64'(ov_id), 64'h1);

      in_valid = 1'b0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
